// File: rtl/car_unit_ctrl_if.sv
// rtl/car_unit_ctrl_if.sv - car-to-drawer request/acknowledge handshake
interface car_draw_if #(
  parameter int IDX_W = 8
) ();
  logic             draw_req;
  logic             draw_erase;
  logic [IDX_W-1:0] path_idx;
  logic             draw_ack;

  modport master (output draw_req, output draw_erase, output path_idx, input draw_ack);
  modport slave  (input draw_req, input draw_erase, input path_idx, output draw_ack);
endinterface

// File: rtl/car_unit_ctrl.sv
// rtl/car_unit_ctrl.sv - per-car FSM with spawn delay, path stepping, hit points and drawer handshake
module car_unit_ctrl #(
  parameter int IDX_W       = 8,
  parameter int PATH_LEN    = 160,
  parameter int HP_W        = 4,
  parameter int HP_INIT     = 10,
  parameter int DLY_W       = 26,
  parameter int SPAWN_DELAY = 50000000,
  parameter int STEP_PERIOD = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            slot_en,
  input  logic            damage_valid,
  input  logic [HP_W-1:0] damage_amt,
  car_draw_if.master      draw,
  output logic [HP_W-1:0] hp,
  output logic            alive,
  output logic            destroyed,
  output logic            escaped
);

  localparam int SLOT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((SPAWN_DELAY > 0) ? SPAWN_DELAY - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PATH_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(STEP_PERIOD - 1);
  localparam logic [HP_W-1:0]   HP_START  = HP_W'(HP_INIT);

  typedef enum logic [2:0] {
    IDLE, DELAY, WAIT_SLOT, ERASE, STEP, DRAW, KILLED, ESCAPED
  } state_e;

  localparam state_e ARM_STATE = (SPAWN_DELAY == 0) ? WAIT_SLOT : DELAY;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]  path_idx_q, path_idx_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              destroyed_q, destroyed_d;
  logic              escaped_q, escaped_d;
  logic              alive_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      dly_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      path_idx_q  <= '0;
      hp_q        <= HP_START;
      destroyed_q <= 1'b0;
      escaped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      path_idx_q  <= path_idx_d;
      hp_q        <= hp_d;
      destroyed_q <= destroyed_d;
      escaped_q   <= escaped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    path_idx_d  = path_idx_q;
    hp_d        = hp_q;
    destroyed_d = 1'b0;
    escaped_d   = 1'b0;
    alive_c     = (state_q == WAIT_SLOT) || (state_q == ERASE) ||
                  (state_q == STEP) || (state_q == DRAW);

    // Saturating damage; a kill is only acted on at the next erase decision.
    if (alive_c && damage_valid) begin
      hp_d = (hp_q > damage_amt) ? hp_q - damage_amt : '0;
    end

    case (state_q)
      IDLE, KILLED, ESCAPED: begin
        if (start) begin
          state_d    = ARM_STATE;
          dly_cnt_d  = '0;
          slot_cnt_d = '0;
          path_idx_d = '0;
          hp_d       = HP_START;
        end
      end
      DELAY: begin
        if (dly_cnt_q == DLY_LAST) state_d = WAIT_SLOT;
        else dly_cnt_d = dly_cnt_q + DLY_W'(1);
      end
      WAIT_SLOT: begin
        if (slot_en) state_d = ERASE;
      end
      ERASE: begin
        if (draw.draw_ack) begin
          if (hp_q == '0) begin
            state_d     = KILLED;
            destroyed_d = 1'b1;
          end else if (path_idx_q == IDX_LAST) begin
            state_d   = ESCAPED;
            escaped_d = 1'b1;
          end else begin
            state_d = STEP;
          end
        end
      end
      STEP: begin
        if (slot_cnt_q == SLOT_LAST) begin
          path_idx_d = path_idx_q + IDX_W'(1);
          slot_cnt_d = '0;
        end else begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end
        state_d = DRAW;
      end
      DRAW: begin
        if (draw.draw_ack) state_d = WAIT_SLOT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is a pure function of state, so it stays stable until the ack moves the FSM on.
  assign draw.draw_req   = (state_q == ERASE) || (state_q == DRAW);
  assign draw.draw_erase = (state_q == ERASE);
  assign draw.path_idx   = path_idx_q;
  assign hp              = hp_q;
  assign alive           = alive_c;
  assign destroyed       = destroyed_q;
  assign escaped         = escaped_q;

endmodule

// File: tb/tb_car_unit_ctrl.sv
// tb/tb_car_unit_ctrl.sv - directed and randomized checks of car_unit_ctrl against a slot-level model
module tb_car_unit_ctrl;

  localparam int PATH_LEN    = 4;
  localparam int STEP_PERIOD = 2;
  localparam int SPAWN_DELAY = 3;
  localparam int HP_INIT     = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       slot_en = 1'b0;
  logic       damage_valid = 1'b0;
  logic [3:0] damage_amt = '0;
  logic [3:0] hp;
  logic       alive, destroyed, escaped;

  int checks = 0;
  int errors = 0;
  int exp_hp, exp_idx, steps;
  bit noise_slots = 1'b0;
  bit term;

  car_draw_if #(.IDX_W(8)) dif ();

  car_unit_ctrl #(
    .IDX_W(8), .PATH_LEN(PATH_LEN), .HP_W(4), .HP_INIT(HP_INIT),
    .DLY_W(26), .SPAWN_DELAY(SPAWN_DELAY), .STEP_PERIOD(STEP_PERIOD)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .slot_en(slot_en),
    .damage_valid(damage_valid), .damage_amt(damage_amt), .draw(dif.master),
    .hp(hp), .alive(alive), .destroyed(destroyed), .escaped(escaped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drawer side: the request is already visible; hold ack off for lat cycles.
  task automatic serve(input bit erase, input int lat);
    chk("req_up", dif.draw_req, 1);
    chk("req_kind", dif.draw_erase, erase);
    for (int i = 0; i < lat; i++) begin
      if (noise_slots) slot_en = 1'($urandom_range(0, 1));
      tick();
      chk("req_hold", dif.draw_req, 1);
      chk("kind_hold", dif.draw_erase, erase);
      chk("idx_hold", dif.path_idx, exp_idx);
    end
    slot_en = 1'b0;
    dif.draw_ack = 1'b1;
    tick();
    dif.draw_ack = 1'b0;
  endtask

  task automatic do_slot(input int lat, output bit done);
    slot_en = 1'b1;
    tick();
    slot_en = 1'b0;
    serve(1'b1, lat);
    done = 1'b1;
    if (exp_hp == 0) begin
      chk("destroyed_pulse", destroyed, 1);
      chk("killed_alive", alive, 0);
      chk("killed_req", dif.draw_req, 0);
      tick();
      chk("destroyed_once", destroyed, 0);
      chk("killed_no_draw", dif.draw_req, 0);
    end else if (exp_idx == PATH_LEN - 1) begin
      chk("escaped_pulse", escaped, 1);
      chk("escaped_alive", alive, 0);
      chk("escaped_idx", dif.path_idx, exp_idx);
      tick();
      chk("escaped_once", escaped, 0);
      chk("escaped_no_draw", dif.draw_req, 0);
      chk("escaped_idx_held", dif.path_idx, exp_idx);
    end else begin
      done = 1'b0;
      chk("step_gap", dif.draw_req, 0);
      chk("step_alive", alive, 1);
      steps++;
      exp_idx = steps / STEP_PERIOD;
      tick();
      chk("draw_idx", dif.path_idx, exp_idx);
      serve(1'b0, lat);
      chk("post_draw_gap", dif.draw_req, 0);
    end
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_hp = HP_INIT;
    exp_idx = 0;
    steps = 0;
    chk("arm_hp", hp, exp_hp);
    chk("arm_idx", dif.path_idx, 0);
    chk("delay_alive", alive, 0);
    for (int i = 1; i < SPAWN_DELAY; i++) begin
      tick();
      chk("delay_alive", alive, 0);
    end
    tick();
    chk("spawn_alive", alive, 1);
    chk("spawn_no_req", dif.draw_req, 0);
  endtask

  task automatic hit(input int amt);
    damage_valid = 1'b1;
    damage_amt = 4'(amt);
    tick();
    damage_valid = 1'b0;
    exp_hp = (exp_hp > amt) ? exp_hp - amt : 0;
    chk("hp_after_hit", hp, exp_hp);
  endtask

  initial begin
    dif.draw_ack = 1'b0;
    tick();
    tick();
    chk("rst_req", dif.draw_req, 0);
    chk("rst_erase", dif.draw_erase, 0);
    chk("rst_idx", dif.path_idx, 0);
    chk("rst_hp", hp, HP_INIT);
    chk("rst_alive", alive, 0);
    chk("rst_destroyed", destroyed, 0);
    chk("rst_escaped", escaped, 0);
    resetn = 1'b1;
    slot_en = 1'b1;
    tick();
    slot_en = 1'b0;
    tick();
    chk("idle_slot_ignored", dif.draw_req, 0);

    // Straight run to the path end.
    arm();
    repeat (3) tick();
    chk("no_req_before_slot", dif.draw_req, 0);
    for (int k = 1; k <= 7; k++) begin
      do_slot(1, term);
      chk("escape_only_on_slot7", term, (k == 7));
    end
    chk("final_idx", dif.path_idx, PATH_LEN - 1);

    // Saturating damage then kill; re-arm from KILLED.
    arm();
    hit(3);
    chk("hp_2", hp, 2);
    hit(3);
    chk("hp_saturated", hp, 0);
    do_slot(1, term);
    chk("kill_terminal", term, 1);
    arm();

    // start ignored while on the field.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_alive", alive, 1);
    tick();
    chk("start_ignored_still", alive, 1);
    chk("start_ignored_req", dif.draw_req, 0);

    // Long erase stall with slot noise, then spurious ack in WAIT_SLOT.
    noise_slots = 1'b1;
    do_slot(10, term);
    noise_slots = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_queued_slot", dif.draw_req, 0);
    end
    dif.draw_ack = 1'b1;
    tick();
    dif.draw_ack = 1'b0;
    chk("spur_ack_req", dif.draw_req, 0);
    chk("spur_ack_idx", dif.path_idx, exp_idx);
    chk("spur_ack_alive", alive, 1);

    // Reset in the middle of a draw handshake.
    slot_en = 1'b1;
    tick();
    slot_en = 1'b0;
    serve(1'b1, 1);
    tick();
    chk("in_draw", dif.draw_req, 1);
    chk("in_draw_kind", dif.draw_erase, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("midrst_req", dif.draw_req, 0);
    chk("midrst_alive", alive, 0);
    chk("midrst_hp", hp, HP_INIT);
    chk("midrst_idx", dif.path_idx, 0);
    slot_en = 1'b1;
    tick();
    slot_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_slot_ignored", dif.draw_req, 0);
    end

    // Randomized waves: random idle gaps, damage and ack latency.
    for (int w = 0; w < 6; w++) begin
      arm();
      term = 1'b0;
      for (int it = 0; it < 100 && !term; it++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 1) == 1) hit($urandom_range(0, 2));
        do_slot($urandom_range(0, 3), term);
      end
      chk("wave_terminated", term, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_unit_ctrl.md
Name: car_unit_ctrl

Overview:
- Parametrised per-car controller for the tower-defence stage. It combines the car FSM with its own datapath: spawn-delay counter, path-index stepping at a configurable speed, hit-point tracking with damage input, a draw/erase request–acknowledge handshake to the shared VGA drawer, and kill/escape termination.
- It can be re-armed, so one instance serves successive waves.
- One instance per car. The wave scheduler drives `start` and `slot_en`. Towers drive the damage inputs.

Parameters:
- IDX_W, 8: path index width.
- PATH_LEN, 160: number of path points. The last index is PATH_LEN-1. Range 2..2^IDX_W.
- HP_W, 4: hit-point width.
- HP_INIT, 10: hit points loaded at reset and on re-arm. Must be ≥1.
- DLY_W, 26: spawn-delay counter width.
- SPAWN_DELAY, 50000000: cycles spent in DELAY. 0 means skip.
- STEP_PERIOD, 1: draw slots per path step (speed divider). Must be ≥1.

Ports:
- clk, in, 1: clock.
- resetn, in, 1: synchronous, active-low reset.
- start, in, 1: wave start / re-arm.
- slot_en, in, 1: one-cycle pulse granting this car a draw slot.
- damage_valid, in, 1: damage strobe.
- damage_amt, in, HP_W: damage amount.
- draw_ack, in, 1: drawer has finished the requested operation.
- draw_req, out, 1: drawer request.
- draw_erase, out, 1: 1 = erase at path_idx, 0 = draw car.
- path_idx, out, IDX_W: current path position.
- hp, out, HP_W: remaining hit points.
- alive, out, 1: car is on the field.
- destroyed, out, 1: one-cycle pulse on kill.
- escaped, out, 1: one-cycle pulse on reaching the path end.

Behaviour:
- Reset (resetn=0 at a clk edge) gives: state IDLE; draw_req=0, draw_erase=0, path_idx=0, hp=HP_INIT, alive=0, destroyed=0, escaped=0; delay and slot counters = 0. Reset takes precedence everywhere, including mid-handshake: draw_req is low the cycle after reset.
- States (3-bit): IDLE, DELAY, WAIT_SLOT, ERASE, STEP, DRAW, KILLED, ESCAPED.
- IDLE:
  - start → DELAY with dly_cnt=0.
  - If SPAWN_DELAY=0, start → WAIT_SLOT directly.
- DELAY: dly_cnt increments each cycle. When dly_cnt==SPAWN_DELAY-1 → WAIT_SLOT. This gives exactly SPAWN_DELAY cycles in DELAY.
- WAIT_SLOT: slot_en → ERASE. Otherwise stay. A slot_en seen in any other state is dropped, never queued.
- ERASE:
  - draw_req=1, draw_erase=1, held stable until draw_ack.
  - On ack: if hp==0 → KILLED; else if path_idx==PATH_LEN-1 → ESCAPED; else → STEP.
  - The decision uses the registered hp. Kill has priority over escape.
- STEP (one cycle):
  - If slot_cnt==STEP_PERIOD-1: path_idx+1 and slot_cnt=0.
  - Else: slot_cnt+1.
  - Then → DRAW.
- DRAW: draw_req=1, draw_erase=0, held until draw_ack, then → WAIT_SLOT.
- KILLED / ESCAPED:
  - Terminal. destroyed (respectively escaped) pulses for one cycle on entry.
  - path_idx is held. draw_req=0.
  - start re-arms: hp=HP_INIT, path_idx=0, slot_cnt=0, then → DELAY (or → WAIT_SLOT if SPAWN_DELAY=0).
- start is ignored in DELAY, WAIT_SLOT, ERASE, STEP and DRAW.
- draw_ack is ignored unless draw_req=1. draw_req deasserts the cycle after ack, so back-to-back ops have at least one idle cycle between them.
- alive=1 in WAIT_SLOT, ERASE, STEP and DRAW only.
- Damage:
  - Accepted only while alive: hp <= (hp > damage_amt) ? hp - damage_amt : 0. Saturating; hp never wraps.
  - Damage in other states is ignored.
  - Damage on the same cycle as an ERASE ack is applied, but the kill is detected at the next ERASE.
- path_idx never exceeds PATH_LEN-1. The escape check precedes the increment.

Test Plan (params: PATH_LEN=4, STEP_PERIOD=2, SPAWN_DELAY=3, HP_INIT=5; drawer acks 1 cycle after req unless stated):
1. start pulse at cycle t → alive=0 through t+3; alive=1 at t+4. draw_req stays 0 until the first slot_en.
2. Repeated slot_en with no damage → path_idx after slots 1..6 is 0,1,1,2,2,3. On slot 7, the erase ack is followed by escaped=1 for exactly one cycle. No DRAW occurs, path_idx stays 3, alive=0.
3. While alive: damage 3 then damage 3 → hp 5→2→0 (saturates, no wrap). On the next slot_en: one erase handshake, then destroyed=1 for one cycle, no draw request, alive=0.
4. Withhold draw_ack for 10 cycles in ERASE → draw_req=1 and draw_erase=1 stable throughout; path_idx unchanged. slot_en pulses during the stall produce no extra operations. A spurious draw_ack in WAIT_SLOT has no effect.
5. start while in WAIT_SLOT → ignored. start in KILLED → hp=5 and path_idx=0 next cycle, DELAY re-entered, alive again 3 cycles later.
6. resetn=0 during DRAW with draw_req=1 → next cycle draw_req=0, alive=0, hp=5, path_idx=0. Subsequent slot_en is ignored until start.
